// File: rtl/serial_pair_pkg.sv
// serial_pair_pkg: shared FSM states, limits and expect-triple helpers for the pair serializer
package serial_pair_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} ser_state_t;
  localparam int MAX_GAP = 15;
  typedef struct packed {
    logic less;
    logic eq;
    logic greater;
  } exp_t;
  function automatic exp_t cmp_words(input logic [31:0] a, input logic [31:0] b);
    return {a < b, a == b, a > b};
  endfunction
endpackage

// File: rtl/serial_pair_serializer_msb_first_shift.sv
// serial_shift_out: W-bit parallel-load shift register emitting its MSB, zero-filling from the LSB
module serial_shift_out #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic         msb
);
  logic [W-1:0] q;
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (load) q <= d;
    else if (shift) q <= {q[W-2:0], 1'b0};
  assign msb = q[W-1];
endmodule

// File: rtl/serial_pair_serializer_msb_first.sv
// serial_pair_serializer_msb_first: shifts accepted (a,b) word pairs out MSB first with first/last framing
// SERIAL_PAIR_SERIALIZER_EXPECT_EN adds registered a<b / a==b / a>b reference strobes on the last bit
module serial_pair_serializer_msb_first
  import serial_pair_pkg::*;
#(
  parameter int W          = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  output logic         out_a,
  output logic         out_b,
  output logic         out_first,
  output logic         out_last,
`ifdef SERIAL_PAIR_SERIALIZER_EXPECT_EN
  output logic         exp_a_less_b,
  output logic         exp_a_eq_b,
  output logic         exp_a_greater_b,
`endif
  output logic         busy
);
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_MAX = CW'(W - 1);
  localparam logic [3:0] GAP_LOAD = GAP_CYCLES > 0 ? 4'((GAP_CYCLES > MAX_GAP ? MAX_GAP : GAP_CYCLES) - 1) : 4'd0;
  ser_state_t state, nxt_state;
  logic [CW-1:0] cnt, nxt_cnt;
  logic [3:0] gap, nxt_gap;
  logic accept, shift, nxt_last;
  always_comb begin
    in_ready = state == ST_IDLE || (GAP_CYCLES == 0 && state == ST_SHIFT && cnt == '0);
    accept = in_valid && in_ready;
    shift = state == ST_SHIFT;
    nxt_state = state;
    nxt_cnt = cnt;
    nxt_gap = gap;
    unique case (state)
      ST_IDLE:
        if (accept) begin
          nxt_state = ST_SHIFT;
          nxt_cnt = CNT_MAX;
        end
      ST_SHIFT:
        if (cnt != '0) nxt_cnt = cnt - 1'b1;
        else if (GAP_CYCLES > 0) begin
          nxt_state = ST_GAP;
          nxt_gap = GAP_LOAD;
        end
        else if (accept) nxt_cnt = CNT_MAX;
        else nxt_state = ST_IDLE;
      ST_GAP:
        if (gap == '0) nxt_state = ST_IDLE;
        else nxt_gap = gap - 1'b1;
      default: nxt_state = ST_IDLE;
    endcase
    nxt_last = nxt_state == ST_SHIFT && nxt_cnt == '0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      gap <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= nxt_state;
      cnt <= nxt_cnt;
      gap <= nxt_gap;
      out_valid <= nxt_state == ST_SHIFT;
      out_first <= accept;
      out_last <= nxt_last;
      busy <= nxt_state != ST_IDLE;
    end
  // Shifters zero-fill, so their MSBs already read 0 whenever no word is in flight
  serial_shift_out #(.W(W)) u_sh_a (.clk, .rst, .load(accept), .shift, .d(in_a), .msb(out_a));
  serial_shift_out #(.W(W)) u_sh_b (.clk, .rst, .load(accept), .shift, .d(in_b), .msb(out_b));
`ifdef SERIAL_PAIR_SERIALIZER_EXPECT_EN
  exp_t exp_q, exp_out;
  always_ff @(posedge clk)
    if (rst) begin
      exp_q <= '0;
      exp_out <= '0;
    end else begin
      if (accept) exp_q <= cmp_words(32'(in_a), 32'(in_b));
      exp_out <= nxt_last ? exp_q : '0;
    end
  assign {exp_a_less_b, exp_a_eq_b, exp_a_greater_b} = exp_out;
`endif
endmodule

// File: tb/tb_serial_pair_serializer_msb_first.sv
// tb_serial_pair_serializer_msb_first: timestamp model checks GAP=0 and GAP=3 instances every cycle, plus literal pins
module tb_serial_pair_serializer_msb_first;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic rdy [2], bsy [2], ov [2], oa [2], ob [2], fst [2], lst [2];
  logic [2:0] ex [2];
  int checks = 0, failures = 0, cyc = 0;
  int ta [2] = '{-1000, -1000};
  logic [W-1:0] ma [2], mb [2];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : u
    serial_pair_serializer_msb_first #(.W(W), .GAP_CYCLES(g ? 3 : 0)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[g]), .in_a(in_a), .in_b(in_b),
      .out_valid(ov[g]), .out_a(oa[g]), .out_b(ob[g]), .out_first(fst[g]), .out_last(lst[g]),
`ifdef SERIAL_PAIR_SERIALIZER_EXPECT_EN
      .exp_a_less_b(ex[g][2]), .exp_a_eq_b(ex[g][1]), .exp_a_greater_b(ex[g][0]),
`endif
      .busy(bsy[g]));
`ifndef SERIAL_PAIR_SERIALIZER_EXPECT_EN
    assign ex[g] = 3'b000;
`endif
  end
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  // A word accepted in cycle ta owns cycles ta+1..ta+W, then GAP idle cycles, before the next accept
  function automatic bit m_ready(int g);
    int gp;
    gp = g ? 3 : 0;
    return cyc >= ta[g] + W + (gp > 0 ? gp + 1 : 0);
  endfunction
  function automatic logic [9:0] model_out(int g);
    int k, gp;
    logic act, ab, bb;
    logic [2:0] e;
    gp = g ? 3 : 0;
    k = cyc - ta[g] - 1;
    act = k >= 0 && k < W;
    ab = act ? ma[g][W-1-k] : 1'b0;
    bb = act ? mb[g][W-1-k] : 1'b0;
    e = 3'b000;
`ifdef SERIAL_PAIR_SERIALIZER_EXPECT_EN
    if (act && k == W - 1) e = {ma[g] < mb[g], ma[g] == mb[g], ma[g] > mb[g]};
`endif
    return {m_ready(g), cyc > ta[g] && cyc <= ta[g] + W + gp, act, ab, bb, act && k == 0, act && k == W - 1, e};
  endfunction
  task automatic tick();
    @(negedge clk);
    if (cyc > 0)
      for (int g = 0; g < 2; g++)
        check($sformatf("cycle%0d_dut%0d", cyc, g), {rdy[g], bsy[g], ov[g], oa[g], ob[g], fst[g], lst[g], ex[g]}, model_out(g));
    @(posedge clk);
    for (int g = 0; g < 2; g++)
      if (rst) ta[g] = -1000;
      else if (in_valid && m_ready(g)) begin
        ta[g] = cyc;
        ma[g] = in_a;
        mb[g] = in_b;
      end
    cyc++;
    #2;
  endtask
  logic [15:0] sa, sb;
  logic [7:0] fp, lp, vp;
  int acc, rc, nv, fv, lv, l1, f2, gc;
  logic [7:0] pa [3] = '{8'd3, 8'd9, 8'd200};
  logic [7:0] pb [3] = '{8'd7, 8'd9, 8'd17};
  logic [2:0] pe [3] = '{3'b100, 3'b010, 3'b001};
  task automatic collect8(input int g);
    sa = '0; sb = '0; fp = '0; lp = '0; vp = '0;
    repeat (8) begin
      sa = {sa[14:0], oa[g]};
      sb = {sb[14:0], ob[g]};
      fp = {fp[6:0], fst[g]};
      lp = {lp[6:0], lst[g]};
      vp = {vp[6:0], ov[g]};
      tick();
    end
  endtask
  initial begin
    tick();
    tick();
    check("reset_ready", rdy[0], 1);
    check("reset_busy", bsy[0], 0);
    check("reset_valid", ov[0], 0);
    rst = 1'b0;
    tick();
    // single word A5/5A
    in_valid = 1'b1; in_a = 8'hA5; in_b = 8'h5A;
    tick();
    in_valid = 1'b0; in_a = '0; in_b = '0;
    collect8(0);
    check("t1_out_a", sa[7:0], 8'hA5);
    check("t1_out_b", sb[7:0], 8'h5A);
    check("t1_first", fp, 8'b1000_0000);
    check("t1_last", lp, 8'b0000_0001);
    check("t1_valid", vp, 8'hFF);
    check("t1_idle_after", {ov[0], bsy[0], rdy[0]}, 3'b001);
    check("t1_gap_after", {ov[1], bsy[1], rdy[1]}, 3'b010);
    repeat (4) tick();
    // back-to-back with no bubble
    acc = 0; rc = 0; nv = 0; fv = -1; lv = -1; sa = '0; sb = '0;
    for (int i = 0; i < 20; i++) begin
      in_valid = acc < 2;
      in_a = acc == 0 ? 8'h01 : 8'hFF;
      in_b = acc == 0 ? 8'h02 : 8'hFF;
      if (i < 16) rc += int'(rdy[0]);
      if (in_valid && rdy[0]) acc++;
      if (ov[0]) begin
        sa = {sa[14:0], oa[0]};
        sb = {sb[14:0], ob[0]};
        nv++;
        if (fv < 0) fv = i;
        lv = i;
      end
      tick();
    end
    in_valid = 1'b0;
    check("t2_accepts", acc, 2);
    check("t2_ready_cycles", rc, 2);
    check("t2_valid_bits", nv, 16);
    check("t2_contiguous", lv - fv + 1, 16);
    check("t2_out_a", sa, 16'h01FF);
    check("t2_out_b", sb, 16'h02FF);
    repeat (6) tick();
    // gap spacing on the GAP=3 instance
    l1 = -1; f2 = -1; gc = 0;
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1; in_a = 8'h81; in_b = 8'h7E;
      if (lst[1] && l1 < 0) l1 = i;
      if (fst[1] && l1 >= 0 && f2 < 0) f2 = i;
      if (l1 >= 0 && f2 < 0 && i > l1 && !ov[1] && !rdy[1]) gc++;
      tick();
    end
    in_valid = 1'b0;
    check("t3_lsb_to_msb", f2 - l1, 5);
    check("t3_gap_cycles", gc, 3);
    repeat (14) tick();
    // reset during the fourth bit
    in_valid = 1'b1; in_a = 8'h3C; in_b = 8'hC3;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("t4_bit3", {ov[0], oa[0], ob[0]}, 3'b110);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int g = 0; g < 2; g++)
      check($sformatf("t4_after_rst_dut%0d", g), {ov[g], oa[g], ob[g], fst[g], lst[g], rdy[g], bsy[g]}, 7'b0000010);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    collect8(0);
    check("t4_restart_a", sa[7:0], 8'h3C);
    check("t4_restart_b", sb[7:0], 8'hC3);
    check("t4_restart_first", fp, 8'b1000_0000);
    repeat (6) tick();
    // payload churn while shifting
    acc = 0;
    in_valid = 1'b1; in_a = 8'h96; in_b = 8'h69;
    if (rdy[0]) acc++;
    tick();
    sa = '0; sb = '0;
    for (int i = 0; i < 8; i++) begin
      in_valid = i < 7;
      in_a = 8'($urandom);
      in_b = 8'($urandom);
      if (in_valid && rdy[0]) acc++;
      sa = {sa[14:0], oa[0]};
      sb = {sb[14:0], ob[0]};
      tick();
    end
    in_valid = 1'b0;
    check("t5_out_a", sa[7:0], 8'h96);
    check("t5_out_b", sb[7:0], 8'h69);
    check("t5_accepts", acc, 1);
    repeat (6) tick();
`ifdef SERIAL_PAIR_SERIALIZER_EXPECT_EN
    for (int p = 0; p < 3; p++) begin
      in_valid = 1'b1; in_a = pa[p]; in_b = pb[p];
      tick();
      in_valid = 1'b0;
      repeat (7) tick();
      check($sformatf("t6_last_%0d", p), lst[0], 1);
      check($sformatf("t6_exp_%0d", p), ex[0], pe[p]);
      tick();
      check($sformatf("t6_exp_clear_%0d", p), ex[0], 0);
      repeat (4) tick();
    end
`endif
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
